uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single SoC UART transmitter between NREQ byte requesters, e.g. the CPU IO-mapped UART register and a hardware echo/debug path.
- Grants are round-robin with line locking: once a requester sends a byte, it keeps the transmitter until it sends LOCK_CHAR (newline) or goes idle for LOCK_TIMEOUT cycles. This stops text lines from different sources interleaving on TXD.
- Sits between the requesters and the UART TX serializer: 115200 baud, 217 clocks per bit at 25 MHz.

Parameters:
- NREQ, 2: number of requesters, 2..8.
- LOCK_CHAR, 8'h0A: byte that releases the line lock.
- LOCK_TIMEOUT, 4096: idle cycles of the lock owner before the lock is forcibly released.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester k has a byte pending.
- req_data  in  8*NREQ  byte of requester k in bits [8k+7:8k]; held stable while req_valid[k] is high and no ack has been seen.
- req_ack  out  NREQ  one-cycle pulse: byte of requester k was captured on the previous edge.
- tx_start  out  1  one-cycle pulse to the serializer.
- tx_data  out  8  byte to serialize; stable from the tx_start pulse until the serializer finishes.
- tx_busy  in  1  serializer busy; rises the cycle after tx_start and falls after the stop bit.
- grant_id  out  clog2(NREQ)  requester that owns the current or last transfer.
- locked  out  1  a line lock is active.

Behaviour:
- Reset (async, immediate): state=IDLE, tx_start=0, tx_data=0, req_ack=0, grant_id=0, locked=0, rr_ptr=0, idle counter=0.
- Reset mid-transfer aborts arbitration state only. The serializer's in-flight byte is the serializer's concern.
- All outputs are registered.
- State machine: IDLE -> START -> WAIT_HI -> WAIT_LO -> IDLE.
- IDLE, eligible set:
  - locked=0: all requesters.
  - locked=1: only grant_id.
- IDLE, selection: if tx_busy=0 and any eligible req_valid is set, pick the first valid index searching from rr_ptr upward with wrap, NREQ-1 -> 0. On that edge:
  - latch tx_data and grant_id;
  - set tx_start=1 and req_ack[winner]=1 for exactly the next cycle;
  - go to START.
- START: drop tx_start and req_ack; go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
  - If tx_busy is still 0 after 2 cycles in WAIT_HI, treat the byte as done and go to IDLE (protects against a serializer that never asserts busy).
- WAIT_LO: on tx_busy=0, go to IDLE.
- Lock update on the edge leaving IDLE with a grant:
  - byte != LOCK_CHAR: locked=1.
  - byte == LOCK_CHAR: locked=0 and rr_ptr = winner+1 mod NREQ.
- Timeout: while locked=1, in IDLE, with req_valid[grant_id]=0, the idle counter increments each cycle. It clears on any grant.
  - When the counter reaches LOCK_TIMEOUT-1: locked=0 and rr_ptr = grant_id+1 mod NREQ, effective the next cycle.
- Other requesters' valids while locked are ignored. Their req_ack stays 0 and they keep holding data.
- Simultaneous timeout expiry and owner req_valid rising on the same cycle: the grant wins and the counter clears.
- Throughput: IDLE re-arbitrates on the first cycle after tx_busy falls. Back-to-back bytes therefore leave at most 1 idle cycle between the serializer stop bit and the next tx_start.
- Exactly one req_ack per accepted byte; never two acks in one cycle.

Test Plan:
- Single requester: req 0 sends 8'h34 with arbiter idle -> tx_start and req_ack[0] high together 1 cycle after valid is sampled, tx_data=8'h34, grant_id=0, locked=1; UART model decodes 0x34 on TXD.
- Line lock: req 0 queues "45*42\n" while req 1 holds 8'h39 valid from the first byte -> TXD carries 34 35 2A 34 32 0A, then 39. req_ack[1] stays 0 until after 0x0A; after 0x0A, locked=0 and rr_ptr=1.
- Round robin: both requesters valid with only LOCK_CHAR bytes, rr_ptr=0 -> grants alternate 0,1,0,1, each tx_start spaced by one full serializer frame (10 bits x 217 = 2170 cycles) plus at most 1 cycle.
- Timeout: req 0 sends 8'h41 then drops valid; req 1 valid -> locked stays 1 for 4096 idle cycles, then drops; req 1 is granted on the following IDLE cycle.
- Missing busy: serializer model never asserts tx_busy -> FSM returns to IDLE 2 cycles after START and serves the next byte with no hang.
- Async reset in WAIT_LO: resetn low mid-frame -> tx_start, req_ack, locked and grant_id go to 0 immediately without waiting for a clock edge. After resetn goes high and tx_busy falls, a new request is granted normally from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer between NREQ byte sources. Grants are round-robin,
// and a source that has sent a byte keeps the line until it sends LOCK_CHAR or goes idle.
module uart_tx_arbiter #(
   parameter int         NREQ         = 2,
   parameter logic [7:0] LOCK_CHAR    = 8'h0A,
   parameter int         LOCK_TIMEOUT = 4096,
   localparam int        GW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ack,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic [GW-1:0]     grant_id,
   output logic              locked,
   output logic [1:0]        dbg_state,
   output logic [GW-1:0]     dbg_rr_ptr
);

   // Requester handshake: req_valid[k] high with req_data[k] held stable until the
   // one-cycle req_ack[k] pulse, which follows the edge that captured the byte.
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_START   = 2'd1;
   localparam logic [1:0] S_WAIT_HI = 2'd2;
   localparam logic [1:0] S_WAIT_LO = 2'd3;
   localparam int         TW        = $clog2(LOCK_TIMEOUT) + 1;

   logic [1:0]      state;
   logic [GW-1:0]   rr_ptr;
   logic [TW-1:0]   idle_cnt;
   logic            hi_cnt;
   logic [NREQ-1:0] eligible;
   logic [GW-1:0]   scan_idx;
   logic [GW-1:0]   winner;
   logic            found;
   logic [7:0]      win_data;
   logic            arb_slot;
   logic            grant;

   function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
      return (int'(v) == NREQ - 1) ? '0 : v + GW'(1);
   endfunction

   always_comb begin
      eligible = locked ? (req_valid & (NREQ'(1) << grant_id)) : req_valid;
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = GW'((int'(rr_ptr) + i) % NREQ);
         if (!found && eligible[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
      win_data = req_data[{winner, 3'b000} +: 8];
   end

   // The cycle tx_busy falls in WAIT_LO already behaves as IDLE, so back-to-back
   // bytes leave only one idle cycle after the stop bit.
   assign arb_slot = (state == S_IDLE) || (state == S_WAIT_LO && !tx_busy);
   assign grant    = arb_slot && !tx_busy && found;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
         req_ack  <= '0;
         grant_id <= '0;
         locked   <= 1'b0;
         rr_ptr   <= '0;
         idle_cnt <= '0;
         hi_cnt   <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         req_ack  <= '0;
         if (grant) begin
            tx_start <= 1'b1;
            req_ack  <= NREQ'(1) << winner;
            tx_data  <= win_data;
            grant_id <= winner;
            idle_cnt <= '0;
            state    <= S_START;
            if (win_data == LOCK_CHAR) begin
               locked <= 1'b0;
               rr_ptr <= wrap_inc(winner);
            end else begin
               locked <= 1'b1;
            end
         end else begin
            if (locked && arb_slot && !req_valid[grant_id]) begin
               if (idle_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                  locked   <= 1'b0;
                  rr_ptr   <= wrap_inc(grant_id);
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            case (state)
               S_START: begin
                  state  <= S_WAIT_HI;
                  hi_cnt <= 1'b0;
               end
               // A serializer that never raises busy must not hang the arbiter.
               S_WAIT_HI: begin
                  if (tx_busy) state <= S_WAIT_LO;
                  else if (hi_cnt) state <= S_IDLE;
                  else hi_cnt <= 1'b1;
               end
               S_WAIT_LO: begin
                  if (!tx_busy) state <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

endmodule
